data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory interface: accepts load/store requests (address, store
//  data, funct3), performs RV32I sub-word access on an internal word-organised RAM after a
//  programmable wait, and returns one response per request. Flags misaligned, out-of-range and
//  illegal-width accesses. Sits beside the datapath in place of an ideal combinational memory.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words (power of two, >=4); byte space 4*DEPTH_WORDS
//  LATENCY      1     wait cycles between acceptance and response (0..7)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I load/store funct3
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low bytes used for sb/sh)
//  rsp_valid   out  1   one-cycle response pulse
//  rsp_rdata   out  32  load data, extended per funct3; 0 for stores and faults
//  rsp_fault   out  1   access rejected (valid only with rsp_valid)
// BEHAVIOUR
//  - Reset values: req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_fault=0, FSM=IDLE.
//  - FSM IDLE->(req_valid) WAIT if LATENCY>0 else RESP; WAIT counts LATENCY edges -> RESP;
//    RESP -> IDLE. Request fields captured at acceptance edge; inputs ignored outside IDLE.
//  - Latency: accepted at edge k -> rsp_valid high for exactly the cycle after edge k+LATENCY+1.
//    No response backpressure; throughput one request per LATENCY+2 cycles.
//  - Stores commit to RAM on the same edge rsp_valid rises; loads sample RAM on that edge, so a
//    load following a store to the same word returns the new data.
//  - rsp_rdata/rsp_fault registered, valid only during rsp_valid, hold value until next response.
//  - Loads: 000 lb sext, 001 lh sext, 010 lw, 100 lbu zext, 101 lhu zext. Stores: 000 sb,
//    001 sh, 010 sw. Little-endian; byte lane = addr[1:0], half lane = addr[1].
//  - Fault (no RAM write, rdata=0): any other funct3; half with addr[0]=1; word with
//    addr[1:0]!=0; addr >= 4*DEPTH_WORDS. Precedence irrelevant: single fault bit.
//  - Reset mid-operation (WAIT/RESP): return to IDLE, pending store discarded, no rsp_valid
//    pulse; RAM contents never cleared by reset.
//  - req_valid held through reset is not accepted until the first cycle reset is low.
// STRUCTURE
//  - Package dmem_pkg: funct3 localparams (F3_B/H/W/BU/HU), state typedef {IDLE,WAIT,RESP},
//    LATENCY width constant.
//  - Sub-module mem_access_align (combinational): funct3+addr[1:0]+wdata+read word ->
//    byte-enable[3:0], aligned write word, extended load data, misalign/illegal fault.
//  - Top holds FSM, wait counter, captured request, RAM array and response registers.
// TESTING
//  1. LATENCY=1: sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_valid 2 cycles after each accept,
//     rdata=0xDEADBEEF, fault=0; req_ready low from accept until after response.
//  2. After (1): lb @0x13->0xFFFFFFDE; lbu @0x13->0x000000DE; lh @0x12->0xFFFFDEAD;
//     lhu @0x10->0x0000BEEF.
//  3. sb wdata=0x12345655 @0x11; sh wdata=0x0000CAFE @0x12; lw @0x10 -> 0xCAFE55EF.
//  4. sh @0x13, sw @0x12, funct3=011 @0x10 -> each fault=1, rdata=0; lw @0x10 unchanged.
//  5. DEPTH_WORDS=1024: lw @0x1000 -> fault=1; lw @0xFFC -> fault=0 with stored data.
//  6. LATENCY=3: sw 0x1 @0x20, assert reset during WAIT -> no rsp_valid, lw @0x20 returns prior
//     value; req_ready=1 in first cycle after reset release. Sweep LATENCY 0..7 timing.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM
// states, the captured-request record and the wait-counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for LATENCY in 0..7
  localparam int LAT_W = 3;

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | counting programmed wait cycles after acceptance
  // RESP  | RAM access edge; response registered on the next edge
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core (master) and the responder (slave).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/data_mem_responder_mem_access_align.sv
// Combinational RV32I sub-word lane steering: byte enables and replicated
// write data for stores, lane extraction plus sign/zero extension for loads,
// and detection of misaligned or illegal-width accesses.
module mem_access_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Decode width/extension; unsigned variants are load-only, so they fault for stores
  always_comb begin
    byte_en   = 4'b0000;
    wword     = '0;
    rdata_ext = '0;
    fault     = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wword     = {4{wdata[7:0]}};
        rdata_ext = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        if (addr_lo[0]) begin
          fault = 1'b1;
        end else begin
          byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
          wword     = {2{wdata[15:0]}};
          rdata_ext = {{16{rhalf[15]}}, rhalf};
        end
      end
      F3_W: begin
        if (addr_lo != 2'b00) begin
          fault = 1'b1;
        end else begin
          byte_en   = 4'b1111;
          wword     = wdata;
          rdata_ext = rword;
        end
      end
      F3_BU: begin
        if (is_store) fault = 1'b1;
        else          rdata_ext = {24'h000000, rbyte};
      end
      F3_HU: begin
        if (is_store || addr_lo[0]) fault = 1'b1;
        else                        rdata_ext = {16'h0000, rhalf};
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// accesses a word-organised RAM and returns a single registered response.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] CNT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_fault_q, rsp_fault_d;

  // Not reset: contents survive a reset by design
  logic [31:0]      ram [DEPTH_WORDS];

  logic [AW-1:0]    word_idx;
  logic [31:0]      rword;
  logic             range_fault;
  logic             align_fault;
  logic             access_fault;
  logic [3:0]       byte_en;
  logic [31:0]      wword;
  logic [31:0]      rdata_ext;
  logic             ram_we;

  assign word_idx     = req_q.addr[AW+1:2];
  assign rword        = ram[word_idx];
  assign range_fault  = |req_q.addr[31:AW+2];
  assign access_fault = range_fault | align_fault;
  // Reset on the commit edge drops the pending store
  assign ram_we       = (state_q == RESP) && req_q.we && !access_fault && !reset;

  mem_access_align u_align (
    .funct3    (req_q.funct3),
    .is_store  (req_q.we),
    .addr_lo   (req_q.addr[1:0]),
    .wdata     (req_q.wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wword     (wword),
    .rdata_ext (rdata_ext),
    .fault     (align_fault)
  );

  // Next-state: capture on accept, down-count wait to terminal zero, respond once
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d.we     = bus.req_we;
          req_d.funct3 = bus.req_funct3;
          req_d.addr   = bus.req_addr;
          req_d.wdata  = bus.req_wdata;
          cnt_d        = CNT_LOAD;
          state_d      = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_fault_d = access_fault;
        rsp_rdata_d = (access_fault || req_q.we) ? 32'h0 : rdata_ext;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Byte-lane RAM write on the response edge
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[word_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives eight responders (LATENCY 0..7) with identical requests and checks
// each against a per-instance array model of the byte-addressed memory.
module tb_data_mem_responder;

  localparam int NI    = 8;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic [NI-1:0] rv_a, rf_a, rr_a;
  logic [31:0]   rd_a [NI];

  int n_vec = 0;
  int n_mis = 0;

  bit [31:0] mem_m [NI][DEPTH];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_lat
    data_mem_responder_if bus ();
    assign bus.req_valid  = req_valid;
    assign bus.req_we     = req_we;
    assign bus.req_funct3 = req_funct3;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign rv_a[g] = bus.rsp_valid;
    assign rf_a[g] = bus.rsp_fault;
    assign rr_a[g] = bus.req_ready;
    assign rd_a[g] = bus.rsp_rdata;
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(g)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes implied by funct3
  function automatic int size_of(input bit [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_fault(input bit we, input bit [2:0] f3, input bit [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || (addr % size_of(f3) != 0) || (addr >= 4 * DEPTH);
  endfunction

  function automatic bit [31:0] load_val(input int inst, input bit [2:0] f3, input bit [31:0] addr);
    bit [31:0] w, v;
    int sz;
    w  = mem_m[inst][(addr / 4) % DEPTH];
    sz = size_of(f3);
    v  = w >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic void store_val(input int inst, input bit [2:0] f3, input bit [31:0] addr,
                                    input bit [31:0] wd);
    bit [31:0] mask;
    int sh, sz, idx;
    sz   = size_of(f3);
    sh   = 8 * (addr % 4);
    idx  = (addr / 4) % DEPTH;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1) << sh;
    mem_m[inst][idx] = (mem_m[inst][idx] & ~mask) | ((wd << sh) & mask);
  endfunction

  // One request to all instances; rst_edge>0 pulses reset sampled at accept edge + rst_edge;
  // pre_rst>0 holds req_valid through that many reset cycles before acceptance.
  task automatic xact(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                      input int rst_edge, input int pre_rst);
    bit              flt;
    bit [31:0]       exp_rd [NI];
    bit [NI-1:0]     exp_v;
    bit [NI-1:0]     done;
    flt  = is_fault(we, f3, addr);
    done = '0;
    for (int g = 0; g < NI; g++) exp_rd[g] = (flt || we) ? 32'h0 : load_val(g, f3, addr);
    @(negedge clk);
    chk("ready_idle", 32'(rr_a), 32'(8'hFF));
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (pre_rst > 0) begin
      reset = 1'b1;
      repeat (pre_rst) @(posedge clk);
      #1;
      chk("ready_in_reset", 32'(rr_a), 32'(8'hFF));
      chk("no_rsp_in_reset", 32'(rv_a), 32'h0);
      @(negedge clk);
      reset = 1'b0;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    chk("ready_busy", 32'(rr_a), 32'h0);
    for (int n = 1; n <= 10; n++) begin
      if (n == rst_edge) reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_v = '0;
      for (int g = 0; g < NI; g++)
        if (g + 1 == n && (rst_edge == 0 || g + 1 < rst_edge)) exp_v[g] = 1'b1;
      chk($sformatf("rsp_valid n=%0d", n), 32'(rv_a), 32'(exp_v));
      for (int g = 0; g < NI; g++) begin
        if (exp_v[g]) begin
          done[g] = 1'b1;
          chk($sformatf("rdata lat=%0d a=%h f3=%0d", g, addr, f3), rd_a[g], exp_rd[g]);
          chk($sformatf("fault lat=%0d a=%h f3=%0d", g, addr, f3), 32'(rf_a[g]), 32'(flt));
        end
      end
      if (n == rst_edge) chk("ready_after_reset", 32'(rr_a), 32'(8'hFF));
    end
    if (we && !flt)
      for (int g = 0; g < NI; g++) if (done[g]) store_val(g, f3, addr, wd);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ready", 32'(rr_a), 32'(8'hFF));
    chk("reset_rsp_valid", 32'(rv_a), 32'h0);
    chk("reset_rsp_fault", 32'(rf_a), 32'h0);
    for (int g = 0; g < NI; g++) chk($sformatf("reset_rdata lat=%0d", g), rd_a[g], 32'h0);

    // Known contents for the working window and the top word
    for (int w = 0; w < 16; w++) xact(1'b1, 3'd2, 32'(4 * w), $urandom, 0, 0);
    xact(1'b1, 3'd2, 32'hFFC, 32'hA5A5_1234, 0, 0);

    // Basic word store/load and sub-word loads
    xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 0);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, 0);
    chk("model_lw_10", load_val(1, 3'd2, 32'h10), 32'hDEAD_BEEF);
    xact(1'b0, 3'd0, 32'h13, 32'h0, 0, 0);
    xact(1'b0, 3'd4, 32'h13, 32'h0, 0, 0);
    xact(1'b0, 3'd1, 32'h12, 32'h0, 0, 0);
    xact(1'b0, 3'd5, 32'h10, 32'h0, 0, 0);

    // Sub-word stores merging into one word
    xact(1'b1, 3'd0, 32'h11, 32'h1234_5655, 0, 0);
    xact(1'b1, 3'd1, 32'h12, 32'h0000_CAFE, 0, 0);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, 0);
    chk("model_merge", load_val(1, 3'd2, 32'h10), 32'hCAFE_55EF);

    // Faulting stores leave memory unchanged
    xact(1'b1, 3'd1, 32'h13, 32'h1111_1111, 0, 0);
    xact(1'b1, 3'd2, 32'h12, 32'h2222_2222, 0, 0);
    xact(1'b1, 3'd3, 32'h10, 32'h3333_3333, 0, 0);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, 0);

    // Range boundary
    xact(1'b0, 3'd2, 32'h1000, 32'h0, 0, 0);
    xact(1'b0, 3'd2, 32'hFFC, 32'h0, 0, 0);

    // Reset during the wait of a store, then read back
    xact(1'b1, 3'd2, 32'h20, 32'h0000_0001, 3, 0);
    xact(1'b0, 3'd2, 32'h20, 32'h0, 0, 0);
    xact(1'b1, 3'd2, 32'h24, 32'h7777_0000, 1, 0);
    xact(1'b0, 3'd2, 32'h24, 32'h0, 0, 0);

    // Request held through reset is taken only after release
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, 2);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit        we;
      bit [2:0]  f3;
      bit [31:0] addr;
      int        r;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      r    = $urandom_range(0, 9);
      addr = (r == 0) ? 32'h1000 + 32'($urandom_range(0, 4095)) :
             (r == 1) ? 32'hFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 63));
      xact(we, f3, addr, $urandom,
           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 0,
           ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
